// File: rtl/branch_commit.sv
// Commit stage for resolved branch/jump results: regfile writeback,
// fetch redirect, trap entry, pipeline flush and branch statistics.
module branch_commit #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int PC_INC       = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [XLEN-1:0]       in_res,
    input  logic [XLEN-1:0]       in_jmp,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_req,
    input  logic                  in_is_branch,
    input  logic                  in_mispredict,
    input  logic                  in_ovf,
    input  logic                  in_illegal,
    output logic                  alu_clear,
    output logic                  rf_we,
    input  logic                  rf_gnt,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  pc_redirect,
    output logic [XLEN-1:0]       pc_target,
    output logic                  pipe_flush,
    output logic                  trap_req,
    output logic                  busy,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           mispred_cnt
);

    typedef enum logic [2:0] {
        IDLE, WB, RESOLVE, REDIRECT, FLUSH, TRAP
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]       res;
        logic [XLEN-1:0]       jmp;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rd;
        logic                  req;
        logic                  is_branch;
        logic                  mispredict;
        logic                  fault;
    } result_t;

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLOAD = FCW'(FLUSH_CYCLES - 1);

    state_t          state;
    state_t          next;
    result_t         cap;
    logic            accept;
    logic [FCW-1:0]  fcnt;

    assign accept = (state == IDLE) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_illegal || in_ovf) begin
                        next = TRAP;
                    end else if (in_rd != '0) begin
                        next = WB;
                    end else begin
                        next = RESOLVE;
                    end
                end
            end
            WB:       if (rf_gnt) next = RESOLVE;
            RESOLVE:  next = cap.mispredict ? REDIRECT : IDLE;
            REDIRECT: next = FLUSH;
            TRAP:     next = FLUSH;
            FLUSH:    if (fcnt == '0) next = IDLE;
            default:  next = IDLE;
        endcase
    end

    always_comb begin
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        pipe_flush  = 1'b0;
        trap_req    = 1'b0;
        unique case (state)
            WB: begin
                rf_we    = 1'b1;
                rf_waddr = cap.rd;
                rf_wdata = cap.res;
            end
            REDIRECT: begin
                pc_redirect = 1'b1;
                pipe_flush  = 1'b1;
                pc_target   = cap.req ? cap.jmp : cap.pc + XLEN'(PC_INC);
            end
            TRAP: begin
                trap_req   = 1'b1;
                pipe_flush = 1'b1;
                pc_target  = cap.pc;
            end
            FLUSH:   pipe_flush = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cap       <= '0;
            alu_clear <= 1'b0;
        end else begin
            alu_clear <= accept;
            if (accept) begin
                cap.res        <= in_res;
                cap.jmp        <= in_jmp;
                cap.pc         <= in_pc;
                cap.rd         <= in_rd;
                cap.req        <= in_req;
                cap.is_branch  <= in_is_branch;
                cap.mispredict <= in_mispredict;
                cap.fault      <= in_illegal | in_ovf;
            end
        end
    end

    // Loaded on the pulse cycle so FLUSH spans exactly FLUSH_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt <= '0;
        end else if (state == REDIRECT || state == TRAP) begin
            fcnt <= FLOAD;
        end else if (state == FLUSH && fcnt != '0) begin
            fcnt <= fcnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (state == RESOLVE) begin
            if (cap.is_branch && branch_cnt != 32'hFFFF_FFFF) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (cap.mispredict && mispred_cnt != 32'hFFFF_FFFF) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_commit.sv
// Directed bench for branch_commit: reset, writeback, redirect,
// PC wrap, grant stall, trap and reset during flush.
module tb_branch_commit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_res;
    logic [31:0] in_jmp;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_req;
    logic        in_is_branch;
    logic        in_mispredict;
    logic        in_ovf;
    logic        in_illegal;
    logic        alu_clear;
    logic        rf_we;
    logic        rf_gnt;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        pipe_flush;
    logic        trap_req;
    logic        busy;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int vectors = 0;
    int miscompares = 0;

    branch_commit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_res(in_res), .in_jmp(in_jmp), .in_pc(in_pc),
        .in_rd(in_rd), .in_req(in_req),
        .in_is_branch(in_is_branch),
        .in_mispredict(in_mispredict),
        .in_ovf(in_ovf), .in_illegal(in_illegal),
        .alu_clear(alu_clear), .rf_we(rf_we),
        .rf_gnt(rf_gnt), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .pipe_flush(pipe_flush),
        .trap_req(trap_req), .busy(busy),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rd, input logic [31:0] res,
                         input logic [31:0] pc, input logic [31:0] jmp,
                         input logic req, input logic br,
                         input logic misp, input logic ill);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_res        = res;
        in_pc         = pc;
        in_jmp        = jmp;
        in_req        = req;
        in_is_branch  = br;
        in_mispredict = misp;
        in_illegal    = ill;
        in_ovf        = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_res = 32'h0; in_jmp = 32'h0;
        in_pc = 32'h0; in_rd = 5'd0; in_req = 1'b0;
        in_is_branch = 1'b0; in_mispredict = 1'b0; in_ovf = 1'b0;
        in_illegal = 1'b0; rf_gnt = 1'b0;

        // reset held 3 cycles with in_valid high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_alu_clear", {31'b0, alu_clear}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
            chk("rst_flush", {31'b0, pipe_flush}, 32'd0);
        end
        chk("rst_redirect", {31'b0, pc_redirect}, 32'd0);
        chk("rst_trap", {31'b0, trap_req}, 32'd0);
        chk("rst_target", pc_target, 32'd0);
        chk("rst_bcnt", branch_cnt, 32'd0);
        chk("rst_mcnt", mispred_cnt, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("idle_clear", {31'b0, alu_clear}, 32'd0);

        // JAL-like writeback, grant immediately
        drive(5'd1, 32'h104, 32'h100, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        rf_gnt = 1'b1;
        tick();
        chk("jal_clear", {31'b0, alu_clear}, 32'd1);
        chk("jal_we", {31'b0, rf_we}, 32'd1);
        chk("jal_waddr", {27'b0, rf_waddr}, 32'd1);
        chk("jal_wdata", rf_wdata, 32'h104);
        chk("jal_busy", {31'b0, busy}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("jal_clear_once", {31'b0, alu_clear}, 32'd0);
        chk("jal_we_once", {31'b0, rf_we}, 32'd0);
        chk("jal_noredir1", {31'b0, pc_redirect}, 32'd0);
        tick();
        chk("jal_idle", {31'b0, busy}, 32'd0);
        chk("jal_noredir2", {31'b0, pc_redirect}, 32'd0);
        chk("jal_bcnt", branch_cnt, 32'd0);
        rf_gnt = 1'b0;

        // BEQ mispredicted taken, rd=0
        drive(5'd0, 32'h0, 32'h40, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("beq_clear", {31'b0, alu_clear}, 32'd1);
        chk("beq_no_we", {31'b0, rf_we}, 32'd0);
        chk("beq_noredir", {31'b0, pc_redirect}, 32'd0);
        in_valid = 1'b0;
        tick();
        chk("beq_redir", {31'b0, pc_redirect}, 32'd1);
        chk("beq_target", pc_target, 32'h200);
        chk("beq_flush0", {31'b0, pipe_flush}, 32'd1);
        chk("beq_bcnt", branch_cnt, 32'd1);
        chk("beq_mcnt", mispred_cnt, 32'd1);
        tick();
        chk("beq_flush1", {31'b0, pipe_flush}, 32'd1);
        chk("beq_redir_once", {31'b0, pc_redirect}, 32'd0);
        tick();
        chk("beq_flush2", {31'b0, pipe_flush}, 32'd1);
        tick();
        chk("beq_flush_end", {31'b0, pipe_flush}, 32'd0);
        chk("beq_idle", {31'b0, busy}, 32'd0);

        // not-taken mispredict with PC wrap
        drive(5'd0, 32'h0, 32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_redir", {31'b0, pc_redirect}, 32'd1);
        chk("wrap_target", pc_target, 32'h0000_0000);
        chk("wrap_bcnt", branch_cnt, 32'd2);
        chk("wrap_mcnt", mispred_cnt, 32'd2);
        tick(); tick(); tick();
        chk("wrap_idle", {31'b0, busy}, 32'd0);

        // grant withheld 4 cycles
        drive(5'd5, 32'hDEAD_BEEF, 32'h10, 32'h500, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_we", {31'b0, rf_we}, 32'd1);
            chk("stall_waddr", {27'b0, rf_waddr}, 32'd5);
            chk("stall_wdata", rf_wdata, 32'hDEAD_BEEF);
            chk("stall_noredir", {31'b0, pc_redirect}, 32'd0);
            if (i == 4) rf_gnt = 1'b1;
            tick();
        end
        rf_gnt = 1'b0;
        chk("stall_resolve_we", {31'b0, rf_we}, 32'd0);
        chk("stall_resolve_redir", {31'b0, pc_redirect}, 32'd0);
        tick();
        chk("stall_redir", {31'b0, pc_redirect}, 32'd1);
        chk("stall_target", pc_target, 32'h500);
        chk("stall_bcnt", branch_cnt, 32'd3);
        chk("stall_mcnt", mispred_cnt, 32'd3);
        tick(); tick(); tick();
        chk("stall_idle", {31'b0, busy}, 32'd0);

        // illegal -> trap, then reset during flush
        drive(5'd3, 32'h55, 32'h80, 32'h900, 1'b1, 1'b1, 1'b1, 1'b1);
        rf_gnt = 1'b1;
        tick();
        in_valid = 1'b0; in_illegal = 1'b0;
        chk("trap_req", {31'b0, trap_req}, 32'd1);
        chk("trap_flush", {31'b0, pipe_flush}, 32'd1);
        chk("trap_target", pc_target, 32'h80);
        chk("trap_no_we", {31'b0, rf_we}, 32'd0);
        chk("trap_noredir", {31'b0, pc_redirect}, 32'd0);
        tick();
        chk("trap_once", {31'b0, trap_req}, 32'd0);
        chk("trap_fl_flush", {31'b0, pipe_flush}, 32'd1);
        chk("trap_fl_no_we", {31'b0, rf_we}, 32'd0);
        chk("trap_bcnt", branch_cnt, 32'd3);
        chk("trap_mcnt", mispred_cnt, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0; rf_gnt = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_flush", {31'b0, pipe_flush}, 32'd0);
        chk("midrst_bcnt", branch_cnt, 32'd0);
        chk("midrst_mcnt", mispred_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
